// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   D_rs_addr/D_rt_addr   source GPRs of the instruction in D
//   D_Tuse_rs/D_Tuse_rt   cycles until D needs each source (3 = unused)
//   D_dst_addr, D_Tnew    destination GPR and result latency of the D instruction
//   D_md_start/div/use    mult/div unit start, div select, HI/LO access
//   stall                 D instruction held this cycle
//   PC_en, F2D_en         PC and F/D register enables
//   D2E_en, D2E_flush     D/E register enable and bubble insert
//   md_busy               mult/div unit busy
//   stall_cnt             stalled cycles since reset

`timescale 1ns/1ps

module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic [4:0]  D_dst_addr,
   input  logic [1:0]  D_Tnew,
   input  logic        D_md_start,
   input  logic        D_md_div,
   input  logic        D_md_use,
   output logic        stall,
   output logic        PC_en,
   output logic        F2D_en,
   output logic        D2E_en,
   output logic        D2E_flush,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   // Shadow scoreboard of the instructions in E and M. W always has Tnew 0,
   // so it can never cause a hazard and is not tracked.
   logic [4:0] E_dst;
   logic [1:0] E_Tnew;
   logic [4:0] M_dst;
   logic [1:0] M_Tnew;
   logic [3:0] md_cnt;

   logic rs_hazard;
   logic rt_hazard;
   logic md_hazard;

   // $0 is hardwired to zero, so it is excluded before comparing against the
   // scoreboard; bubbles also carry dst 0 and must not match it.
   always_comb begin
      rs_hazard = 1'b0;
      rt_hazard = 1'b0;
      if (D_rs_addr != 5'd0) begin
         rs_hazard = ((D_rs_addr == E_dst) && (E_Tnew > D_Tuse_rs)) ||
                     ((D_rs_addr == M_dst) && (M_Tnew > D_Tuse_rs));
      end
      if (D_rt_addr != 5'd0) begin
         rt_hazard = ((D_rt_addr == E_dst) && (E_Tnew > D_Tuse_rt)) ||
                     ((D_rt_addr == M_dst) && (M_Tnew > D_Tuse_rt));
      end
   end

   assign md_busy   = (md_cnt != 4'd0);
   assign md_hazard = D_md_use && md_busy;
   assign stall     = rs_hazard || rt_hazard || md_hazard;

   assign PC_en     = ~stall;
   assign F2D_en    = ~stall;
   assign D2E_en    = 1'b1;
   assign D2E_flush = stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         E_dst  <= 5'd0;
         E_Tnew <= 2'd0;
         M_dst  <= 5'd0;
         M_Tnew <= 2'd0;
      end else begin
         M_dst  <= E_dst;
         M_Tnew <= (E_Tnew != 2'd0) ? (E_Tnew - 2'd1) : 2'd0;
         if (stall) begin
            E_dst  <= 5'd0;
            E_Tnew <= 2'd0;
         end else begin
            E_dst  <= D_dst_addr;
            E_Tnew <= D_Tnew;
         end
      end
   end

   // A start only loads when it actually advances into E; a start arriving
   // while busy is stalled by md_hazard, so the count never reloads mid-op.
   // A pipeline stall does not pause the unit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= 4'd0;
      end else if (!stall && D_md_start) begin
         md_cnt <= D_md_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt != 4'd0) begin
         md_cnt <= md_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 32'd0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core; it drives the enable and flush inputs of the F/D and D/E pipeline registers and the PC register. It keeps a shadow scoreboard of the destination register and remaining result latency (Tnew) of the instructions in E and M. It also tracks the multi-cycle multiply/divide unit. From these it decides each cycle whether the instruction in D may advance, or must be held while a bubble is inserted into E.

## Interface
Parameters
- MULT_CYCLES, 5, busy cycles of the mult unit after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles of the mult unit after a div/divu enters E

Ports
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- D_rs_addr  in  5  rs field of instruction in D
- D_rt_addr  in  5  rt field of instruction in D
- D_Tuse_rs  in  2  cycles until D instruction needs rs (3 = not used)
- D_Tuse_rt  in  2  cycles until D instruction needs rt (3 = not used)
- D_dst_addr  in  5  destination GPR of D instruction (0 = none)
- D_Tnew  in  2  cycles after entering E until result is forwardable (0..2)
- D_md_start  in  1  D instruction is mult/multu/div/divu
- D_md_div  in  1  with D_md_start: 1 = div/divu, 0 = mult/multu
- D_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo or a md start
- stall  out  1  D instruction held this cycle
- PC_en  out  1  PC register write enable (= ~stall)
- F2D_en  out  1  F/D register enable (= ~stall)
- D2E_en  out  1  D/E register enable (constant 1)
- D2E_flush  out  1  bubble into D/E (= stall)
- md_busy  out  1  mult/div unit busy (md_cnt != 0)
- stall_cnt  out  32  total stalled cycles since reset

## Operation
- State: E_dst[4:0], E_Tnew[1:0], M_dst[4:0], M_Tnew[1:0], md_cnt[3:0], stall_cnt[31:0].
- Effective Tnew: E stage uses E_Tnew. M stage uses M_Tnew. W stage is always 0 and is not tracked.
- Hazard on rs: D_rs_addr != 0 and one of the following holds.
  - D_rs_addr == E_dst and E_Tnew > D_Tuse_rs.
  - D_rs_addr == M_dst and M_Tnew > D_Tuse_rs.
- Hazard on rt: same rule with rt fields.
- Register 0 never causes a hazard, even when a matching E_dst or M_dst is 0.
- md hazard: D_md_use and md_busy.
- stall = rs hazard | rt hazard | md hazard. Combinational from current state plus D inputs.
- Each rising edge, not in reset, scoreboard advance:
  - M_dst <= E_dst.
  - M_Tnew <= E_Tnew − 1, saturating at 0.
  - If stall: E_dst <= 0 and E_Tnew <= 0 (bubble).
  - Else: E_dst <= D_dst_addr and E_Tnew <= D_Tnew.
- md counter priority per edge:
  - (1) If ~stall and D_md_start: load DIV_CYCLES if D_md_div, else MULT_CYCLES.
  - (2) Else if md_cnt != 0: decrement.
  - (3) Else hold 0.
- stall_cnt increments by 1 on every edge where stall = 1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async, any time): E_dst = M_dst = 0, E_Tnew = M_Tnew = 0, md_cnt = 0, stall_cnt = 0.
- With neutral D inputs during reset, outputs are: stall = 0, PC_en = 1, F2D_en = 1, D2E_en = 1, D2E_flush = 0, md_busy = 0.
- stall is valid in the same cycle as the D inputs, with zero latency. The surrounding registers sample it at the next edge.
- Load-use: a load (Tnew 2) in E against a consumer with Tuse 0 gives exactly 2 stall cycles.
  - At the first edge, the load moves to M with Tnew 1.
  - At the second edge, Tnew reaches 0 and the consumer advances.
- md_busy goes high on the edge after the start instruction is captured into E. It stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- A new md start while the unit is busy stalls, because D_md_use = 1. The counter therefore never reloads mid-operation.
- A stall while md_cnt != 0 does not suspend the count.
- Reset asserted mid-stall or mid-md operation: all outputs return to the reset values immediately, without waiting for an edge.

## Test plan
- Reset release, D idle (all addrs 0, Tuse 3) -> stall = 0, PC_en = 1, D2E_flush = 0, stall_cnt = 0 for 10 cycles.
- lw $8 (Tnew 2) followed by add using $8 as rs (Tuse 1) -> stall high for 1 cycle, then the add advances. stall_cnt = 1.
- lw $8 followed by beq $8 (Tuse 0) -> stall high for 2 cycles. The E bubble is visible as E_dst = 0 in the next cycle.
- addu $0 with dst 0, followed by a consumer of $0 with Tuse 0 -> no stall.
- div then mflo immediately -> md_busy high for 10 cycles; mflo stalls 10 cycles. mult then mfhi -> 5 cycles.
- Reset pulse asserted mid-div (md_cnt = 6) and mid-stall, between clock edges -> md_busy = 0, stall = 0, stall_cnt = 0 asynchronously.
